mole_scheduler: RTL and testbench

Round sequencer for the whack-a-mole datapath. While the game FSM reports the Game state, it pops one mole at a time on a pseudo-random hole, times the visibility window, and judges the player's button press. It emits the one-cycle `hit_miss` code consumed by the game FSM and keeps score. When the configured number of rounds is exhausted, it raises `rounds_done`, which feeds the FSM's game-timer input.

---
 rtl/mole_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler
//
// Round sequencer for the whack-a-mole datapath. While the game FSM holds
// game_active high, this block waits out an idle gap, pops one mole on a
// pseudo-random hole, times its visibility window, judges the player's
// button press and reports the verdict as a one-cycle hit_miss code. It
// keeps the score and the number of judged rounds, and raises rounds_done
// once the configured number of rounds has been played.
//
// Parameters:
//   NUM_HOLES       number of holes/buttons (power of two, 2..16)
//   MOLE_UP_CYCLES  mole visibility window in clocks (>= 4)
//   GAP_CYCLES      idle gap between moles in clocks (>= 1)
//   GAME_ROUNDS     moles per game (>= 1)
//   SCORE_W         score width
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   game_active  level, high while the game FSM is playing
//   buttons      debounced, active-high button levels
//   ack          one-cycle pulse: hit/miss feedback display finished
//   moles        one-hot visible mole, zero when none
//   hit_miss     00 none, 01 hit, 10 miss; one-cycle pulse
//   score        hits this game, saturating
//   round_count  rounds judged this game
//   rounds_done  level, high once all rounds of the game are judged
//
// Build option:
//   MOLE_SPEEDUP_EN  when defined, the visibility window shrinks by 1/8
//                    after every hit (floored at a quarter of
//                    MOLE_UP_CYCLES) and is restored at each game start.
//                    When undefined the window is the constant
//                    MOLE_UP_CYCLES.

module mole_scheduler #(
    parameter int NUM_HOLES      = 4,
    parameter int MOLE_UP_CYCLES = 50_000_000,
    parameter int GAP_CYCLES     = 25_000_000,
    parameter int GAME_ROUNDS    = 20,
    parameter int SCORE_W        = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             game_active,
    input  logic [NUM_HOLES-1:0]             buttons,
    input  logic                             ack,
    output logic [NUM_HOLES-1:0]             moles,
    output logic [1:0]                       hit_miss,
    output logic [SCORE_W-1:0]               score,
    output logic [$clog2(GAME_ROUNDS+1)-1:0] round_count,
    output logic                             rounds_done
);

    localparam int HOLE_W = $clog2(NUM_HOLES);
    localparam int RC_W   = $clog2(GAME_ROUNDS + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int UP_W   = $clog2(MOLE_UP_CYCLES + 1);

    localparam logic [GAP_W-1:0]   GAP_LOAD    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_ONE     = GAP_W'(1);
    localparam logic [UP_W-1:0]    UP_MAX      = UP_W'(MOLE_UP_CYCLES);
    localparam logic [UP_W-1:0]    UP_ONE      = UP_W'(1);
    localparam logic [RC_W-1:0]    ROUNDS_LAST = RC_W'(GAME_ROUNDS);
    localparam logic [RC_W-1:0]    RC_ONE      = RC_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
    localparam logic [HOLE_W-1:0]  HOLE_ONE    = HOLE_W'(1);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [1:0] HM_NONE = 2'b00;
    localparam logic [1:0] HM_HIT  = 2'b01;
    localparam logic [1:0] HM_MISS = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_UP,
        S_REPORT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]          lfsr;
    logic [GAP_W-1:0]     gap_cnt;
    logic [UP_W-1:0]      up_cnt;
    logic [UP_W-1:0]      up_limit;
    logic [HOLE_W-1:0]    hole;
    logic [HOLE_W-1:0]    hole_cand;
    logic [NUM_HOLES-1:0] buttons_q;
    logic [NUM_HOLES-1:0] press;
    logic [NUM_HOLES-1:0] press_q;
    logic                 gap_last;
    logic                 up_last;
    logic                 start_game;
    logic                 gap_load;
    logic                 hole_latch;
    logic                 report_exit;
    logic [1:0]           verdict;

    assign gap_last = (gap_cnt == '0);
    assign up_last  = (up_cnt == '0);

    // Rising-edge detect against the previous cycle's buttons, so a button
    // that is already held when the mole appears never counts as a press.
    assign press = buttons & ~buttons_q;

    // Candidate hole from the LFSR; a back-to-back repeat is bumped to the
    // next hole, wrapping naturally because NUM_HOLES is a power of two.
    always_comb begin
        hole_cand = lfsr[HOLE_W-1:0];
        if (hole_cand == hole) begin
            hole_cand = hole_cand + HOLE_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-transition strobes used by the datapath.
    // Dropping game_active anywhere in a running round aborts to IDLE.
    always_comb begin
        state_next  = state;
        start_game  = 1'b0;
        gap_load    = 1'b0;
        hole_latch  = 1'b0;
        report_exit = 1'b0;
        verdict     = HM_NONE;
        case (state)
            S_IDLE: begin
                if (game_active) begin
                    start_game = 1'b1;
                    gap_load   = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (!game_active) begin
                    state_next = S_IDLE;
                end else if (gap_last) begin
                    hole_latch = 1'b1;
                    state_next = S_UP;
                end
            end
            S_UP: begin
                // A registered press is judged ahead of the timeout, so a
                // press seen on the last window cycle still wins.
                if (!game_active) begin
                    state_next = S_IDLE;
                end else if (press_q != '0) begin
                    verdict    = (press_q == moles) ? HM_HIT : HM_MISS;
                    state_next = S_REPORT;
                end else if (up_last) begin
                    verdict    = HM_MISS;
                    state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (!game_active) begin
                    state_next = S_IDLE;
                end else begin
                    report_exit = 1'b1;
                    state_next  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!game_active) begin
                    state_next = S_IDLE;
                end else if (ack) begin
                    if (round_count == ROUNDS_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        gap_load   = 1'b1;
                        state_next = S_GAP;
                    end
                end
            end
            S_DONE: begin
                if (!game_active) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef MOLE_SPEEDUP_EN
    localparam logic [UP_W-1:0] UP_FLOOR = UP_MAX >> 2;

    logic [UP_W-1:0] up_shrunk;

    assign up_shrunk = up_limit - (up_limit >> 3);

    // Window shortens after each hit, never below a quarter of the full
    // window, and is restored when a new game starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_limit <= UP_MAX;
        end else if (start_game) begin
            up_limit <= UP_MAX;
        end else if (report_exit && (hit_miss == HM_HIT)) begin
            up_limit <= (up_shrunk > UP_FLOOR) ? up_shrunk : UP_FLOOR;
        end
    end
`else
    assign up_limit = UP_MAX;
`endif

    // Free-running Galois LFSR; it advances in every state so the hole
    // sequence depends on how long the player takes between moles.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr[0]) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ LFSR_MASK;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]};
        end
    end

    // Button edge register. press_q only captures edges while the mole is
    // up, so presses during the gap are never judged.
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons_q <= '0;
            press_q   <= '0;
        end else begin
            buttons_q <= buttons;
            press_q   <= (state == S_UP) ? press : '0;
        end
    end

    // Gap and visibility counters count down to zero; zero marks the last
    // cycle of the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= GAP_LOAD;
            up_cnt  <= UP_MAX - UP_ONE;
        end else begin
            if (gap_load) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && !gap_last) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
            if (hole_latch) begin
                up_cnt <= up_limit - UP_ONE;
            end else if ((state == S_UP) && !up_last) begin
                up_cnt <= up_cnt - UP_ONE;
            end
        end
    end

    // Registered outputs, driven from the next state so they line up with
    // the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            hole        <= '0;
            moles       <= '0;
            hit_miss    <= HM_NONE;
            rounds_done <= 1'b0;
        end else begin
            if (hole_latch) begin
                hole  <= hole_cand;
                moles <= NUM_HOLES'(1) << hole_cand;
            end else if (state_next != S_UP) begin
                moles <= '0;
            end
            hit_miss    <= (state_next == S_REPORT) ? verdict : HM_NONE;
            rounds_done <= (state_next == S_DONE);
        end
    end

    // Score and round counter: cleared at game start, updated when REPORT
    // completes normally, and simply held across an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            score       <= '0;
            round_count <= '0;
        end else if (start_game) begin
            score       <= '0;
            round_count <= '0;
        end else if (report_exit) begin
            round_count <= round_count + RC_ONE;
            if ((hit_miss == HM_HIT) && (score != '1)) begin
                score <= score + SCORE_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler
//
// Directed testbench for mole_scheduler with NUM_HOLES=4, MOLE_UP_CYCLES=20,
// GAP_CYCLES=5, GAME_ROUNDS=3, SCORE_W=8. The bench keeps its own model of
// the hole LFSR and of the visibility window, and checks every output
// against hand-derived values through check_output.

module tb_mole_scheduler;

    localparam int NH    = 4;
    localparam int UPC   = 20;
    localparam int GAPC  = 5;
    localparam int RNDS  = 3;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          game_active;
    logic [NH-1:0] buttons;
    logic          ack;
    logic [NH-1:0] moles;
    logic [1:0]    hit_miss;
    logic [SW-1:0] score;
    logic [1:0]    round_count;
    logic          rounds_done;

    int total = 0;
    int bad   = 0;

    logic [15:0]   m_lfsr;
    logic [1:0]    m_prev;
    logic [1:0]    m_hole;
    logic [1:0]    other;
    logic [NH-1:0] last_moles;
    int            m_win;

    mole_scheduler #(
        .NUM_HOLES     (NH),
        .MOLE_UP_CYCLES(UPC),
        .GAP_CYCLES    (GAPC),
        .GAME_ROUNDS   (RNDS),
        .SCORE_W       (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_active(game_active),
        .buttons    (buttons),
        .ack        (ack),
        .moles      (moles),
        .hit_miss   (hit_miss),
        .score      (score),
        .round_count(round_count),
        .rounds_done(rounds_done)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Galois, mask B400, seed ACE1 on reset.
    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
        end else if (m_lfsr[0]) begin
            m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        end else begin
            m_lfsr <= m_lfsr >> 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Walk through one gap (started by game_active already high in IDLE, or
    // by an ack pulse in WAIT_ACK) and check the mole that follows.
    task automatic start_mole(input bit pulse_ack, input bit hold);
        if (pulse_ack) ack = 1'b1;
        for (int i = 1; i <= GAPC; i++) begin
            tick(1);
            ack = 1'b0;
            check_output("gap_moles", moles, 0);
        end
        m_hole = m_lfsr[1:0];
        if (m_hole == m_prev) m_hole = m_hole + 2'd1;
        m_prev = m_hole;
        other  = m_hole + 2'd1;
        if (hold) buttons = 4'b0001 << m_hole;
        tick(1);
        check_output("mole_pos", moles, 4'b0001 << m_hole);
        check_output("no_repeat", (moles == last_moles), 0);
        last_moles = moles;
    endtask

    // Press b during an UP cycle; verdict shows two cycles later for one cycle.
    task automatic press_and_judge(input logic [NH-1:0] b, input logic [1:0] exp_hm);
        buttons = b;
        tick(1);
        check_output("judge_pre", hit_miss, 0);
        tick(1);
        check_output("judge_hm", hit_miss, exp_hm);
        check_output("judge_moles", moles, 0);
        buttons = '0;
        tick(1);
        check_output("judge_post", hit_miss, 0);
`ifdef MOLE_SPEEDUP_EN
        if (exp_hm == 2'b01) begin
            m_win = m_win - (m_win >> 3);
            if (m_win < (UPC >> 2)) m_win = UPC >> 2;
        end
`endif
    endtask

    // Called in the first UP cycle: count visible cycles until timeout.
    task automatic measure_timeout(input string tag);
        int cnt;
        bit done;
        cnt  = 1;
        done = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            tick(1);
            if (moles == '0) done = 1'b1;
            else cnt++;
        end
        check_output({tag, "_win"}, cnt, m_win);
        check_output({tag, "_miss"}, hit_miss, 2);
        tick(1);
        check_output({tag, "_pulse"}, hit_miss, 0);
    endtask

    initial begin
        reset       = 1'b1;
        game_active = 1'b0;
        ack         = 1'b0;
        buttons     = '0;
        m_prev      = 2'd0;
        last_moles  = 4'b0001;
        m_win       = UPC;

        tick(3);
        check_output("rst_moles", moles, 0);
        check_output("rst_hm", hit_miss, 0);
        check_output("rst_score", score, 0);
        check_output("rst_rc", round_count, 0);
        check_output("rst_done", rounds_done, 0);
        reset = 1'b0;
        tick(2);
        check_output("idle_moles", moles, 0);

        // Game 1: hit, timeout, wrong button, then DONE.
        game_active = 1'b1;
        m_win = UPC;
        start_mole(1'b0, 1'b0);
        tick(2);
        press_and_judge(4'b0001 << m_hole, 2'b01);
        check_output("g1r1_score", score, 1);
        check_output("g1r1_rc", round_count, 1);

        start_mole(1'b1, 1'b0);
        measure_timeout("g1r2");
        check_output("g1r2_score", score, 1);
        check_output("g1r2_rc", round_count, 2);

        start_mole(1'b1, 1'b0);
        press_and_judge(4'b0001 << other, 2'b10);
        check_output("g1r3_score", score, 1);
        check_output("g1r3_rc", round_count, 3);
        check_output("g1r3_done", rounds_done, 0);

        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_output("done_hi", rounds_done, 1);
        tick(4);
        check_output("done_hold", rounds_done, 1);
        check_output("done_moles", moles, 0);
        game_active = 1'b0;
        tick(1);
        check_output("done_clr", rounds_done, 0);
        check_output("done_score", score, 1);
        check_output("done_rc", round_count, 3);
        tick(1);

        // Game 2: held button, double press, abort, restart, reset in REPORT.
        game_active = 1'b1;
        m_win = UPC;
        start_mole(1'b0, 1'b1);
        check_output("g2_score_clr", score, 0);
        check_output("g2_rc_clr", round_count, 0);
        measure_timeout("held");
        buttons = '0;
        check_output("held_rc", round_count, 1);
        check_output("held_score", score, 0);

        start_mole(1'b1, 1'b0);
        press_and_judge((4'b0001 << m_hole) | (4'b0001 << other), 2'b10);
        check_output("dbl_rc", round_count, 2);

        start_mole(1'b1, 1'b0);
        tick(1);
        game_active = 1'b0;
        tick(1);
        check_output("abort_moles", moles, 0);
        check_output("abort_hm", hit_miss, 0);
        check_output("abort_rc", round_count, 2);
        check_output("abort_done", rounds_done, 0);

        game_active = 1'b1;
        m_win = UPC;
        start_mole(1'b0, 1'b0);
        check_output("restart_rc", round_count, 0);
        buttons = 4'b0001 << m_hole;
        tick(2);
        check_output("rst_report_hm", hit_miss, 1);
        reset   = 1'b1;
        buttons = '0;
        tick(1);
        check_output("rst_report_hm0", hit_miss, 0);
        check_output("rst_report_moles", moles, 0);
        check_output("rst_report_score", score, 0);
        game_active = 1'b0;
        tick(1);
        reset      = 1'b0;
        m_prev     = 2'd0;
        last_moles = 4'b0001;
        tick(1);

        // Back-to-back hit games: hole sequence and no-repeat check.
        for (int g = 0; g < 2; g++) begin
            game_active = 1'b1;
            m_win = UPC;
            for (int r = 0; r < RNDS; r++) begin
                start_mole(r != 0, 1'b0);
                press_and_judge(4'b0001 << m_hole, 2'b01);
                check_output("loop_score", score, r + 1);
            end
            ack = 1'b1;
            tick(1);
            ack = 1'b0;
            check_output("loop_done", rounds_done, 1);
            game_active = 1'b0;
            tick(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
